// File: rtl/fft_stage_sequencer.sv
// Address/twiddle sequencer for an in-place radix-2 DIT FFT (bit-reversed input order).
// Walks LOG_N stages of N/2 butterflies. Each butterfly is offered to the datapath as a
// descriptor: the two wing addresses and the twiddle ROM index. A drain gap separates
// stages so that write-back finishes before the next stage reads.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous reset, active low
//   start     one-cycle transform request, honoured only in IDLE
//   busy      transform in progress (first RUN cycle through DONE inclusive)
//   done      one-cycle completion pulse
//   bf_valid  descriptor valid
//   bf_ready  datapath accepts descriptor (transfer on bf_valid && bf_ready)
//   addr_a    upper-wing data address
//   addr_b    lower-wing data address (addr_a + 2^stage)
//   tw_idx    twiddle ROM index
//   stage     current stage, 0 .. LOG_N-1
//   last_bf   final butterfly of the final stage
module fft_stage_sequencer #(
  parameter int unsigned N         = 4096,
  parameter int unsigned LOG_N     = $clog2(N),
  parameter int unsigned TW_W      = $clog2(N / 2),
  parameter int unsigned DRAIN_CYC = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       bf_valid,
  input  logic                       bf_ready,
  output logic [LOG_N-1:0]           addr_a,
  output logic [LOG_N-1:0]           addr_b,
  output logic [TW_W-1:0]            tw_idx,
  output logic [$clog2(LOG_N)-1:0]   stage,
  output logic                       last_bf
);

  localparam int unsigned SW = $clog2(LOG_N);
  localparam int unsigned BW = LOG_N - 1;
  localparam int unsigned DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  localparam logic [SW-1:0] S_LAST     = SW'(LOG_N - 1);
  localparam logic [BW-1:0] B_LAST     = BW'(N / 2 - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [BW-1:0] b_q, b_d;
  logic [DW-1:0] drain_q, drain_d;

  // Next-state logic for the FSM and the stage/butterfly/drain counters.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    b_d     = b_q;
    drain_d = drain_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          s_d     = '0;
          b_d     = '0;
        end
      end
      ST_RUN: begin
        if (bf_ready) begin
          if (b_q == B_LAST) begin
            if (DRAIN_CYC != 0) begin
              state_d = ST_DRAIN;
              drain_d = '0;
            end else if (s_q == S_LAST) begin
              state_d = ST_DONE;
            end else begin
              s_d = s_q + SW'(1);
              b_d = '0;
            end
          end else begin
            b_d = b_q + BW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          if (s_q == S_LAST) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
            s_d     = s_q + SW'(1);
            b_d     = '0;
          end
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      default: begin  // ST_DONE
        state_d = ST_IDLE;
        s_d     = '0;
        b_d     = '0;
        drain_d = '0;
      end
    endcase
  end

  // Butterfly address for the next descriptor: insert a 0 bit at position s into b.
  // Bits below s form pos, bits above form grp; this equals grp*2*span + pos.
  logic [LOG_N-1:0] b_ext, span, lo_mask, nxt_a;
  logic [SW-1:0]    tw_sh;
  logic [TW_W-1:0]  nxt_tw;

  always_comb begin
    b_ext   = {1'b0, b_d};
    span    = LOG_N'(1) << s_d;
    lo_mask = span - LOG_N'(1);
    nxt_a   = ((b_ext & ~lo_mask) << 1) | (b_ext & lo_mask);
    tw_sh   = S_LAST - s_d;
    nxt_tw  = TW_W'((b_ext & lo_mask) << tw_sh);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      b_q     <= '0;
      drain_q <= '0;
      addr_a  <= '0;
      addr_b  <= '0;
      tw_idx  <= '0;
      stage   <= '0;
      last_bf <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      b_q     <= b_d;
      drain_q <= drain_d;
      // Descriptor registers follow the next counters, so they hold under backpressure
      // and read as zero whenever no descriptor is offered.
      if (state_d == ST_RUN) begin
        addr_a  <= nxt_a;
        addr_b  <= nxt_a | span;
        tw_idx  <= nxt_tw;
        stage   <= s_d;
        last_bf <= (s_d == S_LAST) && (b_d == B_LAST);
      end else begin
        addr_a  <= '0;
        addr_b  <= '0;
        tw_idx  <= '0;
        stage   <= '0;
        last_bf <= 1'b0;
      end
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign bf_valid = (state_q == ST_RUN);

endmodule

// File: doc/fft_stage_sequencer.md
Name: fft_stage_sequencer

Overview:
- Sequencer for an in-place radix-2 DIT FFT over N points (bit-reversed input order).
- Walks LOG_N stages of N/2 butterflies. Per butterfly it issues the two data-memory addresses (addr_a, addr_b) and the twiddle index fed to the twiddle-factor ROM.
- Handshakes each butterfly with the butterfly datapath and inserts a drain gap between stages so write-back completes before the next stage reads.

Parameters:
- N, 4096, FFT length; power of two, N >= 4.
- LOG_N, $clog2(N), number of stages and address width.
- TW_W, $clog2(N/2), twiddle index width; matches the twiddle ROM index port.
- DRAIN_CYC, 4, idle cycles after each stage's last accepted butterfly; 0 means no gap.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  synchronous reset, active low.
- start  in  1  one-cycle request to begin a transform; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted through the DONE cycle inclusive.
- done  out  1  one-cycle pulse at transform completion.
- bf_valid  out  1  butterfly descriptor valid.
- bf_ready  in  1  datapath accepts the descriptor; transfer occurs when bf_valid && bf_ready.
- addr_a  out  LOG_N  upper-wing data address.
- addr_b  out  LOG_N  lower-wing data address (addr_a + span).
- tw_idx  out  TW_W  twiddle ROM index for this butterfly.
- stage  out  $clog2(LOG_N)  current stage, 0 to LOG_N-1.
- last_bf  out  1  high with bf_valid on the final butterfly of the final stage.

Behaviour:
- Reset (rst_n==0 at an edge, any state, including mid-transform): state = IDLE, counters = 0. Outputs busy, done, bf_valid, last_bf = 0; addr_a, addr_b, tw_idx, stage = 0. A transform interrupted by reset is abandoned; no done is produced.
- States:
  - IDLE: start=1 -> RUN, with s=0, b=0.
  - RUN: bf_valid=1. On transfer with b == N/2-1: go to DRAIN if DRAIN_CYC > 0; otherwise go to the next stage's RUN, or to DONE after the final stage. On any other transfer, b++.
  - DRAIN: bf_valid=0, counts DRAIN_CYC cycles. Then s++, b=0 and go to RUN; if s was LOG_N-1, go to DONE instead.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Address generation, registered and derived from s and b:
  - span = 2^s, grp = b >> s, pos = b & (span-1).
  - addr_a = grp*2*span + pos; addr_b = addr_a + span.
  - tw_idx = pos << (LOG_N-1-s), truncated to TW_W bits.
- Latency:
  - The first descriptor appears in the cycle after the edge that samples start.
  - With bf_ready held at 1, one butterfly transfers per cycle.
  - done occurs LOG_N*(N/2+DRAIN_CYC)+1 cycles after the start-sampling edge.
- Backpressure: while bf_valid && !bf_ready, addr_a, addr_b, tw_idx, stage and last_bf stay stable and the counters hold.
- start while busy: ignored, not queued. start in the DONE cycle: ignored. start in the first IDLE cycle after DONE: accepted.
- The twiddle ROM has 1-cycle registered latency. Aligning tw_idx to data is the datapath's responsibility; the sequencer adds no delay.
- No counter wraps silently. b never exceeds N/2-1 and s never exceeds LOG_N-1.

Test Plan:
- N=8, DRAIN_CYC=3, bf_ready=1, start pulse at edge 0:
  - Stage 0 (a,b,tw): (0,1,0) (2,3,0) (4,5,0) (6,7,0).
  - Stage 1: (0,2,0) (1,3,2) (4,6,0) (5,7,2).
  - Stage 2: (0,4,0) (1,5,1) (2,6,2) (3,7,3).
  - done pulses exactly in cycle 22; busy low again in cycle 23.
- Same as above, but bf_ready=0 for 5 cycles during stage 1, butterfly 2 -> outputs held at (4,6,0), stage=1; done delayed to cycle 27.
- DRAIN_CYC=0, N=8 -> 12 consecutive bf_valid cycles with no gaps; done in cycle 13; last_bf high only on (3,7,3).
- start re-pulsed while busy, plus start held high through DONE -> only one transform runs; the next transform begins the cycle after IDLE is re-entered.
- rst_n=0 for one edge during stage 1 -> next cycle: IDLE, all outputs 0, no done pulse. A subsequent start restarts from stage 0, (0,1,0).
- N=4096, bf_ready randomly toggled -> each stage has exactly 2048 transfers, every address 0..4095 is covered exactly once per stage, tw_idx < 2048, done exactly once.
